simd_alu_pipe: RTL and testbench
================================

SIMD_ALU_PIPE -- requirements
Module: simd_alu_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 64, total operand width in bits.
REQ-002 SHALL have parameter ELEM_W, default 16, lane width; legal values are 8, 16 and 32; LANES = DATA_W/ELEM_W.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 SHALL have port CLR, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): upstream handshake.
REQ-006 SHALL have ports op (input, 3), a (input, DATA_W), b (input, DATA_W) and imm (input, 8): the operation and its operands.
REQ-007 SHALL have ports out_valid (output, 1) and out_ready (input, 1): downstream handshake.
REQ-008 SHALL have port result, output, DATA_W bits: the packed result.
REQ-009 SHALL have port lane_sat, output, LANES bits: per-lane saturation for the result currently presented.
REQ-010 SHALL have ports sat_clr (input, 1) and sat_sticky (output, LANES): sticky saturation status and its clear.

Function
REQ-011 SHALL accept an operation on a cycle with in_valid && in_ready, and deliver it on a cycle with out_valid && out_ready.
REQ-012 SHALL have two register stages: S1 captures op/a/b/imm; S2 holds result and lane_sat.
REQ-013 Latency SHALL be 2 cycles: out_valid rises on the second posedge after acceptance when out_ready is held high.
REQ-014 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-015 Each stage SHALL advance when its downstream stage is empty or is being drained in the same cycle.
REQ-016 in_ready SHALL equal !(S1 valid && S2 valid && !out_ready); no transaction SHALL be dropped or duplicated.
REQ-017 While out_valid=1 && out_ready=0, result and lane_sat SHALL hold stable.
REQ-018 Opcodes SHALL operate lane-wise on ELEM_W lanes; lane i occupies bits [i*ELEM_W +: ELEM_W].
REQ-019 Opcodes 0-2: 0 PADD (a+b, wrap); 1 PSUB (a-b, wrap); 2 PADDS (a+b, signed saturation to [-2^(E-1), 2^(E-1)-1]).
REQ-020 Opcodes 3-4: 3 PADDUS (a+b, unsigned saturation to 2^E-1); 4 PSUBS (a-b, signed saturation).
REQ-021 Opcode 5 PSHUF: result lane i = b lane imm[2i+1:2i] for i=0..3, legal only when LANES==4; otherwise result = b.
REQ-022 Opcodes 6 PCMPEQ and 7 PCMPGT (signed a>b): result lane = all-ones if true, else zero.
REQ-023 Saturating ops SHALL compute with one guard bit per lane; lane_sat[i]=1 iff lane i was clamped; for all other ops lane_sat=0.
REQ-024 sat_sticky SHALL OR in lane_sat on every output handshake.
REQ-025 sat_clr SHALL zero sat_sticky; when sat_clr coincides with an output handshake, the result is the new lane_sat (set wins).
REQ-026 imm SHALL be ignored by every op except PSHUF.

Reset
REQ-027 While CLR=1, asynchronously: S1/S2 valids, out_valid, result, lane_sat and sat_sticky SHALL be 0.
REQ-028 in_ready SHALL be 1 during and after reset.
REQ-029 CLR asserted mid-operation SHALL discard all in-flight transactions; no output handshake SHALL follow for them.

Structure
REQ-030 A shared package SHALL hold the op enum (PADD..PCMPGT) and the legal ELEM_W constants.
REQ-031 A sub-module simd_lane_alu (one ELEM_W lane: add/sub/saturate/compare) SHALL be instantiated LANES times by generate; PSHUF muxing stays in the top.
REQ-032 Parameter legality (DATA_W % ELEM_W == 0, ELEM_W in {8,16,32}) SHALL be checked at elaboration.

Verification
REQ-033 PADDS, ELEM_W=16: a=0x7FFF_0001_8000_0005, b=0x0001_0001_FFFF_FFFB -> result 0x7FFF_0002_8000_0000, lane_sat=4'b1010.
REQ-034 PADDUS, ELEM_W=8: a=0xFF..FF, b=0x01..01 -> result all 0xFF, lane_sat all ones, sat_sticky all ones after the handshake.
REQ-035 PSHUF: imm=0x1B, b=0x4444_3333_2222_1111 -> result 0x1111_2222_3333_4444, lane_sat=0.
REQ-036 Back-to-back ops 1,2,3 with out_ready low for 3 cycles -> in_ready drops after two accepts, results emerge in order, none lost.
REQ-037 Assert CLR one cycle after acceptance -> out_valid stays 0; all outputs read 0.
REQ-038 Assert sat_clr on the same cycle as a saturating handshake with lane_sat=4'b0001 -> sat_sticky=4'b0001 next cycle.

Source files
------------

// File: rtl/simd_alu_pipe_pkg.sv
// Shared definitions for the SIMD ALU pipeline: opcode encoding and legal lane widths.
package simd_alu_pipe_pkg;

  localparam int ELEM_W_8  = 8;
  localparam int ELEM_W_16 = 16;
  localparam int ELEM_W_32 = 32;

  typedef enum logic [2:0] {
    OP_PADD   = 3'd0,
    OP_PSUB   = 3'd1,
    OP_PADDS  = 3'd2,
    OP_PADDUS = 3'd3,
    OP_PSUBS  = 3'd4,
    OP_PSHUF  = 3'd5,
    OP_PCMPEQ = 3'd6,
    OP_PCMPGT = 3'd7
  } simd_op_e;

  function automatic bit elem_w_legal(input int w);
    return (w == ELEM_W_8) || (w == ELEM_W_16) || (w == ELEM_W_32);
  endfunction

endpackage

// File: rtl/simd_lane_alu.sv
// One ELEM_W lane: wrap/saturating add and subtract plus signed/equality compares.
module simd_lane_alu
  import simd_alu_pipe_pkg::*;
#(
  parameter int ELEM_W = 16
) (
  input  simd_op_e          i_op,
  input  logic [ELEM_W-1:0] i_a,
  input  logic [ELEM_W-1:0] i_b,
  output logic [ELEM_W-1:0] o_res,
  output logic              o_sat
);

  localparam logic [ELEM_W-1:0] SMAX = {1'b0, {(ELEM_W-1){1'b1}}};
  localparam logic [ELEM_W-1:0] SMIN = {1'b1, {(ELEM_W-1){1'b0}}};
  localparam logic [ELEM_W-1:0] ONES = {ELEM_W{1'b1}};

  // One guard bit per lane: sign-extended for signed ops, zero-extended for unsigned.
  logic [ELEM_W:0] w_sadd;
  logic [ELEM_W:0] w_ssub;
  logic [ELEM_W:0] w_uadd;
  logic            w_gt;

  assign w_sadd = {i_a[ELEM_W-1], i_a} + {i_b[ELEM_W-1], i_b};
  assign w_ssub = {i_a[ELEM_W-1], i_a} - {i_b[ELEM_W-1], i_b};
  assign w_uadd = {1'b0, i_a} + {1'b0, i_b};
  assign w_gt   = $signed(i_a) > $signed(i_b);

  // Lane result and clamp flag selection.
  always_comb begin
    o_res = '0;
    o_sat = 1'b0;
    case (i_op)
      OP_PADD: o_res = w_sadd[ELEM_W-1:0];
      OP_PSUB: o_res = w_ssub[ELEM_W-1:0];
      OP_PADDS: begin
        if (w_sadd[ELEM_W] != w_sadd[ELEM_W-1]) begin
          o_sat = 1'b1;
          o_res = w_sadd[ELEM_W] ? SMIN : SMAX;
        end else begin
          o_res = w_sadd[ELEM_W-1:0];
        end
      end
      OP_PADDUS: begin
        if (w_uadd[ELEM_W]) begin
          o_sat = 1'b1;
          o_res = ONES;
        end else begin
          o_res = w_uadd[ELEM_W-1:0];
        end
      end
      OP_PSUBS: begin
        if (w_ssub[ELEM_W] != w_ssub[ELEM_W-1]) begin
          o_sat = 1'b1;
          o_res = w_ssub[ELEM_W] ? SMIN : SMAX;
        end else begin
          o_res = w_ssub[ELEM_W-1:0];
        end
      end
      OP_PCMPEQ: begin
        if (i_a == i_b) begin
          o_res = ONES;
        end else begin
          o_res = '0;
        end
      end
      OP_PCMPGT: begin
        if (w_gt) begin
          o_res = ONES;
        end else begin
          o_res = '0;
        end
      end
      default: o_res = i_b;
    endcase
  end

endmodule

// File: rtl/simd_alu_pipe.sv
// Two-stage lane-parallel SIMD ALU with valid/ready handshakes and sticky saturation status.
module simd_alu_pipe
  import simd_alu_pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ELEM_W = 16
) (
  input  logic                       CLK,
  input  logic                       CLR,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 op,
  input  logic [DATA_W-1:0]          a,
  input  logic [DATA_W-1:0]          b,
  input  logic [7:0]                 imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          result,
  output logic [DATA_W/ELEM_W-1:0]   lane_sat,
  input  logic                       sat_clr,
  output logic [DATA_W/ELEM_W-1:0]   sat_sticky
);

  localparam int LANES = DATA_W / ELEM_W;

  if (!elem_w_legal(ELEM_W) || ((DATA_W % ELEM_W) != 0)) begin : g_param_err
    $error("simd_alu_pipe: ELEM_W must be 8, 16 or 32 and divide DATA_W");
  end

  logic              r_s1_valid;
  simd_op_e          r_s1_op;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;
  logic [7:0]        r_s1_imm;
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_result;
  logic [LANES-1:0]  r_lane_sat;
  logic [LANES-1:0]  r_sat_sticky;

  logic              w_s2_adv;
  logic              w_out_hs;
  logic [DATA_W-1:0] w_lane_res;
  logic [LANES-1:0]  w_lane_sat;
  logic [DATA_W-1:0] w_shuf;
  logic [DATA_W-1:0] w_next_res;
  logic [LANES-1:0]  w_next_sat;

  assign w_s2_adv   = !r_s2_valid || out_ready;
  assign w_out_hs   = r_s2_valid && out_ready;
  assign in_ready   = !(r_s1_valid && r_s2_valid && !out_ready);
  assign out_valid  = r_s2_valid;
  assign result     = r_result;
  assign lane_sat   = r_lane_sat;
  assign sat_sticky = r_sat_sticky;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    simd_lane_alu #(.ELEM_W(ELEM_W)) u_lane (
      .i_op  (r_s1_op),
      .i_a   (r_s1_a[i*ELEM_W +: ELEM_W]),
      .i_b   (r_s1_b[i*ELEM_W +: ELEM_W]),
      .o_res (w_lane_res[i*ELEM_W +: ELEM_W]),
      .o_sat (w_lane_sat[i])
    );
  end

  // Shuffle only exists for four-lane configurations; elsewhere it degenerates to b.
  if (LANES == 4) begin : g_shuf
    for (genvar i = 0; i < 4; i++) begin : g_sel
      logic [1:0] w_sel;
      assign w_sel = r_s1_imm[2*i +: 2];
      assign w_shuf[i*ELEM_W +: ELEM_W] = r_s1_b[w_sel*ELEM_W +: ELEM_W];
    end
  end else begin : g_noshuf
    assign w_shuf = r_s1_b;
  end

  // Select between lane ALU output and shuffle for the S2 load.
  always_comb begin
    w_next_res = w_lane_res;
    w_next_sat = w_lane_sat;
    if (r_s1_op == OP_PSHUF) begin
      w_next_res = w_shuf;
      w_next_sat = '0;
    end else begin
      w_next_res = w_lane_res;
      w_next_sat = w_lane_sat;
    end
  end

  // Operand stage: loads whenever it is empty or handing off to S2 this cycle.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_PADD;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_imm   <= 8'h00;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op  <= simd_op_e'(op);
        r_s1_a   <= a;
        r_s1_b   <= b;
        r_s1_imm <= imm;
      end
    end
  end

  // Result stage: holds steady under backpressure, refills when drained or empty.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_lane_sat <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result   <= w_next_res;
        r_lane_sat <= w_next_sat;
      end
    end
  end

  // Sticky saturation: a handshake's lane_sat survives a coincident clear.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_sat_sticky <= '0;
    end else if (w_out_hs) begin
      r_sat_sticky <= (sat_clr ? '0 : r_sat_sticky) | r_lane_sat;
    end else if (sat_clr) begin
      r_sat_sticky <= '0;
    end
  end

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Directed bench for simd_alu_pipe: a 16-bit-lane and an 8-bit-lane instance share stimulus.
module tb_simd_alu_pipe;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        in_valid;
  logic        out_ready;
  logic        sat_clr;
  logic [2:0]  op;
  logic [63:0] a;
  logic [63:0] b;
  logic [7:0]  imm;

  logic        in_ready16, out_valid16;
  logic [63:0] result16;
  logic [3:0]  lane_sat16, sticky16;
  logic        in_ready8, out_valid8;
  logic [63:0] result8;
  logic [7:0]  lane_sat8, sticky8;

  int n_cmp = 0;
  int n_err = 0;

  simd_alu_pipe #(.DATA_W(64), .ELEM_W(16)) u_dut16 (
    .CLK(CLK), .CLR(CLR), .in_valid(in_valid), .in_ready(in_ready16),
    .op(op), .a(a), .b(b), .imm(imm),
    .out_valid(out_valid16), .out_ready(out_ready), .result(result16),
    .lane_sat(lane_sat16), .sat_clr(sat_clr), .sat_sticky(sticky16)
  );

  simd_alu_pipe #(.DATA_W(64), .ELEM_W(8)) u_dut8 (
    .CLK(CLK), .CLR(CLR), .in_valid(in_valid), .in_ready(in_ready8),
    .op(op), .a(a), .b(b), .imm(imm),
    .out_valid(out_valid8), .out_ready(out_ready), .result(result8),
    .lane_sat(lane_sat8), .sat_clr(sat_clr), .sat_sticky(sticky8)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one op into an idle pipe with out_ready high; return the presented output and latency.
  task automatic run_op(input logic [2:0] vo, input logic [63:0] va, input logic [63:0] vb,
                        input logic [7:0] vi, output logic [63:0] r, output logic [3:0] s,
                        output int lat);
    op = vo; a = va; b = vb; imm = vi; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 8) begin
      @(posedge CLK); #1;
      lat++;
    end
    r = result16;
    s = lane_sat16;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    CLR = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
    op = 3'd0; a = 64'h0; b = 64'h0; imm = 8'h00;
    #1;
    n_cmp++; if (out_valid16 !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", out_valid16); end
    n_cmp++; if (in_ready16 !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b expected 1", in_ready16); end
    n_cmp++; if (result16 !== 64'h0) begin n_err++; $display("FAIL rst_result: got %h expected 0", result16); end
    n_cmp++; if (lane_sat16 !== 4'h0) begin n_err++; $display("FAIL rst_lane_sat: got %b expected 0", lane_sat16); end
    n_cmp++; if (sticky16 !== 4'h0) begin n_err++; $display("FAIL rst_sticky: got %b expected 0", sticky16); end
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    CLR = 1'b0;
    #1;
    n_cmp++; if (in_ready16 !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %b expected 1", in_ready16); end
  endtask

  task automatic test_lane_ops();
    logic [2:0]  vo [0:6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    logic [63:0] va [0:6] = '{64'h0001_FFFF_7FFF_1234, 64'h0000_0005_8000_1234,
                              64'h7FFF_0001_8000_0005, 64'hFFFF_8000_0001_7FFF,
                              64'h8000_7FFF_0005_0000, 64'h1234_0000_FFFF_5555,
                              64'h0001_FFFF_8000_7FFF};
    logic [63:0] vb [0:6] = '{64'h0002_0001_0001_1111, 64'h0001_0003_0001_0234,
                              64'h0001_0001_FFFF_FFFB, 64'h0001_8000_0001_0001,
                              64'h0001_FFFF_0007_8000, 64'h1234_0001_FFFF_5554,
                              64'h0000_0000_7FFF_7FFF};
    logic [63:0] er [0:6] = '{64'h0003_0000_8000_2345, 64'hFFFF_0002_7FFF_1000,
                              64'h7FFF_0002_8000_0000, 64'hFFFF_FFFF_0002_8000,
                              64'h8000_7FFF_FFFE_7FFF, 64'hFFFF_0000_FFFF_0000,
                              64'hFFFF_0000_0000_0000};
    logic [3:0]  es [0:6] = '{4'b0000, 4'b0000, 4'b1010, 4'b1100, 4'b1101, 4'b0000, 4'b0000};
    logic [63:0] r;
    logic [3:0]  s;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      run_op(vo[i], va[i], vb[i], 8'hA5, r, s, lat);
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL op%0d_latency: got %0d expected 1", vo[i], lat); end
      n_cmp++; if (r !== er[i]) begin n_err++; $display("FAIL op%0d_result: got %h expected %h", vo[i], r, er[i]); end
      n_cmp++; if (s !== es[i]) begin n_err++; $display("FAIL op%0d_lane_sat: got %b expected %b", vo[i], s, es[i]); end
    end
    n_cmp++; if (sticky16 !== 4'b1111) begin n_err++; $display("FAIL sticky_accum: got %b expected 1111", sticky16); end
  endtask

  task automatic test_pshuf();
    logic [7:0]  vi [0:1] = '{8'h1B, 8'h00};
    logic [63:0] er [0:1] = '{64'h1111_2222_3333_4444, 64'h1111_1111_1111_1111};
    logic [63:0] r;
    logic [3:0]  s;
    int          lat;
    for (int i = 0; i < 2; i++) begin
      run_op(3'd5, 64'hDEAD_BEEF_0BAD_F00D, 64'h4444_3333_2222_1111, vi[i], r, s, lat);
      n_cmp++; if (r !== er[i]) begin n_err++; $display("FAIL pshuf_%h_result: got %h expected %h", vi[i], r, er[i]); end
      n_cmp++; if (s !== 4'b0000) begin n_err++; $display("FAIL pshuf_%h_lane_sat: got %b expected 0000", vi[i], s); end
    end
  endtask

  task automatic test_sticky_clear();
    int w;
    op = 3'd2; a = 64'h0000_0000_0000_7FFF; b = 64'h0000_0000_0000_0001; imm = 8'h00;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid16 && w < 8) begin @(posedge CLK); #1; w++; end
    n_cmp++; if (lane_sat16 !== 4'b0001) begin n_err++; $display("FAIL clr_hs_lane_sat: got %b expected 0001", lane_sat16); end
    sat_clr = 1'b1;
    @(posedge CLK); #1;
    sat_clr = 1'b0;
    n_cmp++; if (sticky16 !== 4'b0001) begin n_err++; $display("FAIL clr_hs_sticky: got %b expected 0001", sticky16); end
    sat_clr = 1'b1;
    @(posedge CLK); #1;
    sat_clr = 1'b0;
    n_cmp++; if (sticky16 !== 4'b0000) begin n_err++; $display("FAIL clr_only_sticky: got %b expected 0000", sticky16); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  vo [0:2] = '{3'd1, 3'd2, 3'd3};
    logic [63:0] va [0:2] = '{64'h0000_0005_8000_1234, 64'h7FFF_0001_8000_0005, 64'hFFFF_8000_0001_7FFF};
    logic [63:0] vb [0:2] = '{64'h0001_0003_0001_0234, 64'h0001_0001_FFFF_FFFB, 64'h0001_8000_0001_0001};
    logic [63:0] er [0:2] = '{64'hFFFF_0002_7FFF_1000, 64'h7FFF_0002_8000_0000, 64'hFFFF_FFFF_0002_8000};
    logic [3:0]  es [0:2] = '{4'b0000, 4'b1010, 4'b1100};
    int  sent = 0;
    int  got = 0;
    int  dup = 0;
    logic acc, hs;
    for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
      in_valid  = (sent < 3);
      op = vo[sent % 3]; a = va[sent % 3]; b = vb[sent % 3]; imm = 8'h00;
      out_ready = (cyc >= 3);
      #1;
      acc = in_valid && in_ready16;
      hs  = out_valid16 && out_ready;
      if (cyc == 2) begin
        n_cmp++; if (in_ready16 !== 1'b0 || sent != 2) begin n_err++; $display("FAIL b2b_in_ready_drop: in_ready %b after %0d accepts, expected 0 after 2", in_ready16, sent); end
        n_cmp++; if (out_valid16 !== 1'b1 || result16 !== er[0]) begin n_err++; $display("FAIL b2b_stall_hold: valid %b result %h expected 1 %h", out_valid16, result16, er[0]); end
      end
      if (hs) begin
        n_cmp++; if (result16 !== er[got] || lane_sat16 !== es[got]) begin n_err++; $display("FAIL b2b_out%0d: got %h/%b expected %h/%b", got, result16, lane_sat16, er[got], es[got]); end
        got++;
      end
      if (acc) sent++;
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    n_cmp++; if (got != 3 || sent != 3) begin n_err++; $display("FAIL b2b_count: sent %0d got %0d expected 3/3", sent, got); end
    for (int i = 0; i < 3; i++) begin
      if (out_valid16) dup++;
      @(posedge CLK); #1;
    end
    n_cmp++; if (dup != 0) begin n_err++; $display("FAIL b2b_no_dup: extra valid cycles %0d expected 0", dup); end
  endtask

  task automatic test_clr_mid();
    int seen = 0;
    op = 3'd0; a = 64'h1111_1111_1111_1111; b = 64'h2222_2222_2222_2222; imm = 8'h00;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    CLR = 1'b1;
    #1;
    n_cmp++; if (out_valid16 !== 1'b0) begin n_err++; $display("FAIL clr_mid_out_valid: got %b expected 0", out_valid16); end
    n_cmp++; if (result16 !== 64'h0 || lane_sat16 !== 4'h0) begin n_err++; $display("FAIL clr_mid_outputs: got %h/%b expected 0/0", result16, lane_sat16); end
    n_cmp++; if (sticky16 !== 4'h0) begin n_err++; $display("FAIL clr_mid_sticky: got %b expected 0", sticky16); end
    n_cmp++; if (in_ready16 !== 1'b1) begin n_err++; $display("FAIL clr_mid_in_ready: got %b expected 1", in_ready16); end
    @(posedge CLK); #1;
    CLR = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid16) seen++;
      @(posedge CLK); #1;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL clr_mid_no_output: valid cycles %0d expected 0", seen); end
  endtask

  task automatic test_paddus8();
    int w = 0;
    op = 3'd3; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h0101_0101_0101_0101; imm = 8'h00;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    while (!out_valid8 && w < 8) begin @(posedge CLK); #1; w++; end
    n_cmp++; if (result8 !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL paddus8_result: got %h expected all ff", result8); end
    n_cmp++; if (lane_sat8 !== 8'hFF) begin n_err++; $display("FAIL paddus8_lane_sat: got %b expected 11111111", lane_sat8); end
    @(posedge CLK); #1;
    n_cmp++; if (sticky8 !== 8'hFF) begin n_err++; $display("FAIL paddus8_sticky: got %b expected 11111111", sticky8); end
  endtask

  initial begin
    test_reset();
    test_lane_ops();
    test_pshuf();
    test_sticky_clear();
    test_back_to_back();
    test_clr_mid();
    test_paddus8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
